// File: rtl/operand_entry_fsm_pkg.sv
// Shared definitions for the operand entry path.
//   KEY_CLEAR / KEY_ENTER : function key codes
//   entry_state_t         : operand entry FSM states
//   analyse_keys()        : one-hot / multi-press check plus 4-bit encode
package input_pkg;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [3:0] KEY_CLEAR     = 4'd10;
    localparam logic [3:0] KEY_ENTER     = 4'd11;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        HOLD    = 2'd2
    } entry_state_t;

    typedef struct packed {
        logic       single;
        logic       multi;
        logic [3:0] code;
    } key_info_t;

    function automatic key_info_t analyse_keys(input logic [15:0] vec);
        key_info_t  info;
        logic [4:0] cnt;
        info = '0;
        cnt  = '0;
        for (int i = 0; i < 16; i++) begin
            if (vec[i]) begin
                cnt       = cnt + 5'd1;
                info.code = 4'(i);
            end
        end
        info.single = (cnt == 5'd1);
        info.multi  = (cnt > 5'd1);
        return info;
    endfunction

endpackage

// File: rtl/operand_entry_fsm_if.sv
// Operand handshake towards the sequential multiplier core.
//   operand_a/operand_b : captured operands
//   op_valid            : operands valid
//   mult_ready          : core accepts operands
// master = operand entry block, slave = multiplier core.
interface operand_entry_fsm_if #(parameter int N = 8);
    logic [N-1:0] operand_a;
    logic [N-1:0] operand_b;
    logic         op_valid;
    logic         mult_ready;

    modport master (output operand_a, output operand_b, output op_valid, input mult_ready);
    modport slave  (input operand_a, input operand_b, input op_valid, output mult_ready);
endinterface

// File: rtl/operand_entry_fsm_key_edge_detect.sv
// New-press detector for the debounced key vector.
//   clk, reset : clock, async active-low reset
//   keys       : debounced key levels
//   single     : exactly one key went high this cycle
//   multi      : more than one key went high this cycle
//   code       : index of the pressed key (valid with single)
module key_edge_detect
    import input_pkg::*;
#(
    parameter int NKEYS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] keys,
    output logic             single,
    output logic             multi,
    output logic [3:0]       code
);

    logic [NKEYS-1:0] prev;
    logic [NKEYS-1:0] rise;
    key_info_t        info;

    // Reset to all ones so that keys held through reset never look like new presses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev <= '1;
        else        prev <= keys;
    end

    assign rise   = keys & ~prev;
    assign info   = analyse_keys(rise);
    assign single = info.single;
    assign multi  = info.multi;
    assign code   = info.code;

endmodule

// File: rtl/operand_entry_fsm.sv
// Operand entry controller: assembles decimal operands A and B from key
// presses and hands them to the multiplier core.
//   clk, reset  : clock, async active-low reset
//   botones_db  : debounced key levels
//   mult_bus    : operand_a/operand_b/op_valid out, mult_ready in
//   display_val : operand currently being typed (operand_b while holding)
//   phase       : 0 entering A, 1 entering B, 2 holding for core
//   key_error   : one-cycle pulse when an input is rejected
//
// state   | meaning
// ENTER_A | digits go to acc_a
// ENTER_B | digits go to acc_b
// HOLD    | operands offered, waiting for mult_ready
module operand_entry_fsm
    import input_pkg::*;
#(
    parameter int N     = 8,
    parameter int NKEYS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NKEYS-1:0]      botones_db,
    operand_entry_fsm_if.master   mult_bus,
    output logic [N-1:0]          display_val,
    output logic [1:0]            phase,
    output logic                  key_error
);

    localparam int W = N + 4;

    entry_state_t state, state_nxt;
    logic [N-1:0] acc_a, acc_a_nxt, acc_b, acc_b_nxt;
    logic [N-1:0] opa, opa_nxt, opb, opb_nxt;
    logic         valid, valid_nxt, err_nxt;
    logic         single, multi;
    logic [3:0]   code;
    logic [N-1:0] acc_cur, acc_upd;
    logic [W-1:0] digit_sum;
    logic         overflow;

    key_edge_detect #(.NKEYS(NKEYS)) u_edge (
        .clk    (clk),
        .reset  (reset),
        .keys   (botones_db),
        .single (single),
        .multi  (multi),
        .code   (code)
    );

    assign acc_cur   = (state == ENTER_B) ? acc_b : acc_a;
    // N+4 bits hold (2^N-1)*10+9 without wrapping.
    assign digit_sum = {4'b0000, acc_cur} * W'(10) + W'(code);
    assign overflow  = |digit_sum[W-1:N];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ENTER_A;
            acc_a     <= '0;
            acc_b     <= '0;
            opa       <= '0;
            opb       <= '0;
            valid     <= 1'b0;
            key_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc_a     <= acc_a_nxt;
            acc_b     <= acc_b_nxt;
            opa       <= opa_nxt;
            opb       <= opb_nxt;
            valid     <= valid_nxt;
            key_error <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_a_nxt = acc_a;
        acc_b_nxt = acc_b;
        opa_nxt   = opa;
        opb_nxt   = opb;
        valid_nxt = valid;
        err_nxt   = 1'b0;
        acc_upd   = acc_cur;

        if (multi) begin
            err_nxt = 1'b1;
        end else if (single) begin
            if (state == HOLD) begin
                err_nxt = 1'b1;
            end else if (code <= KEY_DIGIT_MAX) begin
                if (overflow) err_nxt = 1'b1;
                else          acc_upd = digit_sum[N-1:0];
            end else if (code == KEY_CLEAR) begin
                acc_upd = '0;
            end else if (code == KEY_ENTER) begin
                if (state == ENTER_A) begin
                    opa_nxt   = acc_a;
                    acc_b_nxt = '0;
                    state_nxt = ENTER_B;
                end else begin
                    opb_nxt   = acc_b;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end
            end else begin
                err_nxt = 1'b1;
            end
        end

        if (state == ENTER_A && !(single && code == KEY_ENTER)) acc_a_nxt = acc_upd;
        if (state == ENTER_B && !(single && code == KEY_ENTER)) acc_b_nxt = acc_upd;

        if (state == HOLD && valid && mult_bus.mult_ready) begin
            valid_nxt = 1'b0;
            acc_a_nxt = '0;
            state_nxt = ENTER_A;
        end
    end

    always_comb begin
        case (state)
            ENTER_A: display_val = acc_a;
            ENTER_B: display_val = acc_b;
            default: display_val = opb;
        endcase
    end

    assign phase              = state;
    assign mult_bus.operand_a = opa;
    assign mult_bus.operand_b = opb;
    assign mult_bus.op_valid  = valid;

endmodule
